// File: rtl/memory_pkg.sv
// Shared types and helpers for the byte-enabled dual-port data memory.
package memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    // Number of byte-offset bits below the word index.
    function automatic int offs_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/memory_port_decode.sv
// Byte-address decode for one port: word index plus misalign/out-of-range error.
module memory_port_decode
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic [31:0]           address,
    output logic [ADDR_WIDTH-1:0] index,
    output logic                  error
);

    localparam int OFFS = offs_bits(DATA_WIDTH);
    localparam int TOP  = ADDR_WIDTH + OFFS;

    logic [1:0] cause;

    assign index = address[TOP-1:OFFS];

    // A shift by TOP == 32 yields zero, so a full 32-bit map never reports out-of-range.
    assign cause = ((address[OFFS-1:0] != '0)    ? ERR_MISALIGN : ERR_NONE)
                 | (((address >> TOP) != 32'd0)  ? ERR_RANGE    : ERR_NONE);

    assign error = (cause != ERR_NONE);

endmodule

// File: rtl/memory_dual_port_be.sv
// True dual-port data memory with byte-lane writes, address checking and a post-reset clear sweep.
// Define MEMORY_OUTPUT_REG_EN to add a second output register stage (response latency 2).
module memory_dual_port_be
    import memory_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 12,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done,

    input  logic                    req_valid_a,
    input  logic                    write_enable_a,
    input  logic [DATA_WIDTH/8-1:0] byte_enable_a,
    input  logic [31:0]             address_a,
    input  logic [DATA_WIDTH-1:0]   write_data_a,
    output logic [DATA_WIDTH-1:0]   read_data_a,
    output logic                    rsp_valid_a,
    output logic                    error_a,

    input  logic                    req_valid_b,
    input  logic                    write_enable_b,
    input  logic [DATA_WIDTH/8-1:0] byte_enable_b,
    input  logic [31:0]             address_b,
    input  logic [DATA_WIDTH-1:0]   write_data_b,
    output logic [DATA_WIDTH-1:0]   read_data_b,
    output logic                    rsp_valid_b,
    output logic                    error_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;

    logic [ADDR_WIDTH-1:0] idx_a, idx_b;
    logic                  dec_err_a, dec_err_b;
    logic                  acc_a, acc_b, wr_a, wr_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b, store_a;

    memory_port_decode #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_decode_a (
        .address (address_a),
        .index   (idx_a),
        .error   (dec_err_a)
    );

    memory_port_decode #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_decode_b (
        .address (address_b),
        .index   (idx_b),
        .error   (dec_err_b)
    );

    assign acc_a = req_valid_a & init_done;
    assign acc_b = req_valid_b & init_done;
    assign wr_a  = acc_a & write_enable_a & ~dec_err_a;
    assign wr_b  = acc_b & write_enable_b & ~dec_err_b;

    // Reads see the array before this cycle's writes, giving read-first across ports.
    assign old_a = mem[idx_a];
    assign old_b = mem[idx_b];

    // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
    always_comb begin
        merged_a = old_a;
        merged_b = old_b;
        store_a  = old_a;
        for (int l = 0; l < LANES; l++) begin
            if (byte_enable_a[l]) begin
                merged_a[l*8 +: 8] = write_data_a[l*8 +: 8];
                store_a[l*8 +: 8]  = write_data_a[l*8 +: 8];
            end else if (wr_b && (idx_b == idx_a) && byte_enable_b[l]) begin
                store_a[l*8 +: 8]  = write_data_b[l*8 +: 8];
            end
            if (byte_enable_b[l]) begin
                merged_b[l*8 +: 8] = write_data_b[l*8 +: 8];
            end
        end
    end

    // NOTE: the array itself is never reset; the clear sweep initialises it after every reset.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[sweep_cnt] <= CLEAR_VALUE;
        end else begin
            if (wr_b) mem[idx_b] <= merged_b;
            // Port A is written last so its lanes win on a same-index collision.
            if (wr_a) mem[idx_a] <= store_a;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
            init_done <= 1'b0;
        end else if (state == ST_CLEAR) begin
            sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
            if (sweep_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                state     <= ST_READY;
                init_done <= 1'b1;
            end
        end
    end

    logic                  rsp_valid_a_q, error_a_q, rsp_valid_b_q, error_b_q;
    logic [DATA_WIDTH-1:0] read_data_a_q, read_data_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_a_q <= 1'b0;
            error_a_q     <= 1'b0;
            read_data_a_q <= '0;
            rsp_valid_b_q <= 1'b0;
            error_b_q     <= 1'b0;
            read_data_b_q <= '0;
        end else begin
            rsp_valid_a_q <= acc_a;
            error_a_q     <= acc_a & dec_err_a;
            if (acc_a) begin
                read_data_a_q <= dec_err_a ? '0 : (write_enable_a ? merged_a : old_a);
            end
            rsp_valid_b_q <= acc_b;
            error_b_q     <= acc_b & dec_err_b;
            if (acc_b) begin
                read_data_b_q <= dec_err_b ? '0 : (write_enable_b ? merged_b : old_b);
            end
        end
    end

`ifdef MEMORY_OUTPUT_REG_EN
    logic                  rsp_valid_a_q2, error_a_q2, rsp_valid_b_q2, error_b_q2;
    logic [DATA_WIDTH-1:0] read_data_a_q2, read_data_b_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_a_q2 <= 1'b0;
            error_a_q2     <= 1'b0;
            read_data_a_q2 <= '0;
            rsp_valid_b_q2 <= 1'b0;
            error_b_q2     <= 1'b0;
            read_data_b_q2 <= '0;
        end else begin
            rsp_valid_a_q2 <= rsp_valid_a_q;
            error_a_q2     <= error_a_q;
            read_data_a_q2 <= read_data_a_q;
            rsp_valid_b_q2 <= rsp_valid_b_q;
            error_b_q2     <= error_b_q;
            read_data_b_q2 <= read_data_b_q;
        end
    end

    assign rsp_valid_a = rsp_valid_a_q2;
    assign error_a     = error_a_q2;
    assign read_data_a = read_data_a_q2;
    assign rsp_valid_b = rsp_valid_b_q2;
    assign error_b     = error_b_q2;
    assign read_data_b = read_data_b_q2;
`else
    assign rsp_valid_a = rsp_valid_a_q;
    assign error_a     = error_a_q;
    assign read_data_a = read_data_a_q;
    assign rsp_valid_b = rsp_valid_b_q;
    assign error_b     = error_b_q;
    assign read_data_b = read_data_b_q;
`endif

endmodule

// File: tb/tb_memory_dual_port_be.sv
// Directed, table-driven bench for memory_dual_port_be at its default 4096x32 configuration.
module tb_memory_dual_port_be;

`ifdef MEMORY_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int SWEEP = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done;
    logic        req_valid_a = 1'b0, write_enable_a = 1'b0;
    logic [3:0]  byte_enable_a = '0;
    logic [31:0] address_a = '0, write_data_a = '0, read_data_a;
    logic        rsp_valid_a, error_a;
    logic        req_valid_b = 1'b0, write_enable_b = 1'b0;
    logic [3:0]  byte_enable_b = '0;
    logic [31:0] address_b = '0, write_data_b = '0, read_data_b;
    logic        rsp_valid_b, error_b;

    int n_checks = 0;
    int n_fail   = 0;

    memory_dual_port_be dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_done      (init_done),
        .req_valid_a    (req_valid_a),
        .write_enable_a (write_enable_a),
        .byte_enable_a  (byte_enable_a),
        .address_a      (address_a),
        .write_data_a   (write_data_a),
        .read_data_a    (read_data_a),
        .rsp_valid_a    (rsp_valid_a),
        .error_a        (error_a),
        .req_valid_b    (req_valid_b),
        .write_enable_b (write_enable_b),
        .byte_enable_b  (byte_enable_b),
        .address_b      (address_b),
        .write_data_b   (write_data_b),
        .read_data_b    (read_data_b),
        .rsp_valid_b    (rsp_valid_b),
        .error_b        (error_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req_a;
        logic        we_a;
        logic [3:0]  be_a;
        logic [31:0] addr_a;
        logic [31:0] wd_a;
        logic        req_b;
        logic        we_b;
        logic [3:0]  be_b;
        logic [31:0] addr_b;
        logic [31:0] wd_b;
        logic        exp_err_a;
        logic [31:0] exp_a;
        logic        exp_err_b;
        logic [31:0] exp_b;
        logic        chk_data;
    } vec_t;

    vec_t vecs [12];

    // Drives one request pair for a single cycle and checks the responses LAT cycles later.
    task automatic apply(input int id, input vec_t v);
        @(negedge clk);
        req_valid_a = v.req_a; write_enable_a = v.we_a; byte_enable_a = v.be_a;
        address_a = v.addr_a;  write_data_a = v.wd_a;
        req_valid_b = v.req_b; write_enable_b = v.we_b; byte_enable_b = v.be_b;
        address_b = v.addr_b;  write_data_b = v.wd_b;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
        check($sformatf("vec%0d rsp_valid_a", id), 32'(rsp_valid_a), 32'(v.req_a));
        check($sformatf("vec%0d rsp_valid_b", id), 32'(rsp_valid_b), 32'(v.req_b));
        if (v.req_a) begin
            check($sformatf("vec%0d error_a", id), 32'(error_a), 32'(v.exp_err_a));
            if (v.chk_data) check($sformatf("vec%0d read_data_a", id), read_data_a, v.exp_a);
        end
        if (v.req_b) begin
            check($sformatf("vec%0d error_b", id), 32'(error_b), 32'(v.exp_err_b));
            if (v.chk_data) check($sformatf("vec%0d read_data_b", id), read_data_b, v.exp_b);
        end
    endtask

    // Counts rising edges until init_done; also counts any response seen meanwhile.
    task automatic wait_init(output int cycles, output int seen);
        cycles = 0;
        seen   = 0;
        while (!init_done && cycles < 6000) begin
            @(posedge clk); #1;
            cycles++;
            if (rsp_valid_a || rsp_valid_b) seen++;
        end
    endtask

    int cyc, seen;
    int n_rsp;
    int rsp_at [3];
    logic [31:0] rsp_dat [3];

    initial begin
        //          rq we be     addr          wdata         rq we be     addr          wdata         ea  exp_a          eb  exp_b        chk
        vecs[0]  = '{1, 0, 4'h0, 32'h0000,     32'h0,        1, 0, 4'h0, 32'h3FFC,     32'h0,        0, 32'h00000000, 0, 32'h00000000, 1};
        vecs[1]  = '{1, 1, 4'hF, 32'h0100,     32'hAABBCCDD, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'hAABBCCDD, 0, 32'h0,        1};
        vecs[2]  = '{1, 1, 4'h5, 32'h0100,     32'h11223344, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'hAA22CC44, 0, 32'h0,        1};
        vecs[3]  = '{1, 0, 4'h0, 32'h0102,     32'h0,        1, 0, 4'hF, 32'h0100,     32'h0,        1, 32'h00000000, 0, 32'hAA22CC44, 1};
        vecs[4]  = '{1, 1, 4'hF, 32'h4000,     32'h12345678, 0, 0, 4'h0, 32'h0,        32'h0,        1, 32'h00000000, 0, 32'h0,        1};
        vecs[5]  = '{1, 0, 4'h0, 32'h0000,     32'h0,        1, 1, 4'h0, 32'h0100,     32'hFFFFFFFF, 0, 32'h00000000, 0, 32'hAA22CC44, 1};
        vecs[6]  = '{1, 1, 4'hF, 32'h0020,     32'hDEADBEEF, 1, 0, 4'h0, 32'h0020,     32'h0,        0, 32'hDEADBEEF, 0, 32'h00000000, 1};
        vecs[7]  = '{1, 0, 4'h0, 32'h4001,     32'h0,        1, 0, 4'h0, 32'h0020,     32'h0,        1, 32'h00000000, 0, 32'hDEADBEEF, 1};
        vecs[8]  = '{1, 1, 4'h3, 32'h0024,     32'h11112222, 1, 1, 4'hF, 32'h0024,     32'h33334444, 0, 32'h0,        0, 32'h0,        0};
        vecs[9]  = '{1, 0, 4'h0, 32'h0024,     32'h0,        1, 0, 4'h0, 32'h0024,     32'h0,        0, 32'h33332222, 0, 32'h33332222, 1};
        vecs[10] = '{1, 1, 4'h8, 32'h0024,     32'hAB000000, 1, 1, 4'hF, 32'hFFFC,     32'h55555555, 0, 32'hAB332222, 1, 32'h00000000, 1};
        vecs[11] = '{1, 0, 4'h0, 32'h0100,     32'h0,        1, 0, 4'h0, 32'h3FFC,     32'h0,        0, 32'hAA22CC44, 0, 32'h00000000, 1};

        // Reset state.
        #1;
        check("reset init_done",   32'(init_done),   32'd0);
        check("reset rsp_valid_a", 32'(rsp_valid_a), 32'd0);
        check("reset rsp_valid_b", 32'(rsp_valid_b), 32'd0);
        check("reset error_a",     32'(error_a),     32'd0);
        check("reset read_data_a", read_data_a,      32'd0);
        check("reset read_data_b", read_data_b,      32'd0);
        repeat (3) @(negedge clk);

        // Full sweep with requests held high: none may be answered before init_done.
        req_valid_a = 1'b1; address_a = 32'h0;
        req_valid_b = 1'b1; address_b = 32'h4;
        rst_n = 1'b1;
        wait_init(cyc, seen);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        check("sweep length",            32'(cyc),  32'(SWEEP));
        check("responses during sweep",  32'(seen), 32'd0);

        foreach (vecs[i]) apply(i, vecs[i]);

        // Response is a single-cycle strobe.
        @(posedge clk); #1;
        check("rsp_valid_a drops", 32'(rsp_valid_a), 32'd0);

        // Back-to-back reads return in order, one per cycle.
        apply(100, '{1, 1, 4'hF, 32'h0, 32'h00000010, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h00000010, 0, 32'h0, 1});
        apply(101, '{1, 1, 4'hF, 32'h4, 32'h00000020, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h00000020, 0, 32'h0, 1});
        apply(102, '{1, 1, 4'hF, 32'h8, 32'h00000030, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h00000030, 0, 32'h0, 1});
        n_rsp = 0;
        @(negedge clk);
        req_valid_a = 1'b1; write_enable_a = 1'b0; address_a = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) address_a = 32'h4;
            else if (k == 2) address_a = 32'h8;
            else if (k == 3) req_valid_a = 1'b0;
            if (rsp_valid_a && n_rsp < 3) begin
                rsp_at[n_rsp]  = k;
                rsp_dat[n_rsp] = read_data_a;
                n_rsp++;
            end
        end
        check("pipeline response count", 32'(n_rsp), 32'd3);
        for (int i = 0; i < n_rsp; i++) begin
            check($sformatf("pipeline rsp%0d cycle", i), 32'(rsp_at[i]), 32'(i + LAT));
            check($sformatf("pipeline rsp%0d data", i),  rsp_dat[i],     32'((i + 1) * 16));
        end

        // Reset during an in-flight response drops it at once.
        @(negedge clk);
        req_valid_a = 1'b1; write_enable_a = 1'b0; address_a = 32'h100;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid_a = 1'b0;
        #1;
        check("mid-op reset rsp_valid_a", 32'(rsp_valid_a), 32'd0);
        check("mid-op reset read_data_a", read_data_a,      32'd0);
        check("mid-op reset init_done",   32'(init_done),   32'd0);

        // Partial sweep, then reset again at cycle 2000.
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (init_done || rsp_valid_a || rsp_valid_b) seen++;
        end
        check("partial sweep quiet", 32'(seen), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-sweep reset init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cyc, seen);
        check("restarted sweep length", 32'(cyc), 32'(SWEEP));

        // The restarted sweep has cleared earlier writes.
        apply(200, '{1, 0, 4'h0, 32'h0100, 32'h0, 1, 0, 4'h0, 32'h0020, 32'h0, 0, 32'h0, 0, 32'h0, 1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
